// File: rtl/serial_packet_decoder.sv
// rtl/serial_packet_decoder.sv - SOF/LEN/payload/CHK frame decoder with buffered valid/ready drain
// Optional inter-byte timeout: define PACKET_DECODER_TIMEOUT_EN to enable.
module serial_packet_decoder #(
  parameter logic [7:0] SyncByte       = 8'hA5,
  parameter int         MaxPayload     = 16,
  parameter int         ClockFrequency = 16000000,
  parameter int         BaudRate       = 115200,
  parameter int         TimeoutBits    = 30
) (
  input  logic       iClock,
  input  logic       iResetN,
  input  logic [7:0] iData,
  input  logic       iReceived,
  input  logic       iError,
  output logic [7:0] oData,
  output logic       oValid,
  input  logic       iReady,
  output logic       oFirst,
  output logic       oLast,
  output logic       oFrameOk,
  output logic       oFrameError,
  output logic [1:0] oErrorCode,
  output logic       oOverrun
);

  localparam int         IndexWidth = (MaxPayload > 1) ? $clog2(MaxPayload) : 1;
  localparam logic [7:0] MaxLength  = 8'(MaxPayload);

  typedef enum logic [2:0] {
    sHunt,
    sLength,
    sPayload,
    sChecksum,
    sDrain
  } stateT;

  stateT      state, stateNext;
  logic [7:0] frameLength, frameLengthNext;
  logic [7:0] byteCount, byteCountNext;
  logic [7:0] sum, sumNext;
  logic       frameOk, frameOkNext;
  logic       frameError, frameErrorNext;
  logic [1:0] errorCode, errorCodeNext;
  logic       overrun, overrunNext;
  logic       bufferWrite;
  logic       inFrame;
  logic       timeoutHit;
  logic [7:0] lastIndex;

  logic [7:0] buffer [MaxPayload];

  // Byte count doubles as the write index while filling and the read index while draining.
  assign lastIndex = frameLength - 8'd1;
  assign inFrame   = (state == sLength) || (state == sPayload) || (state == sChecksum);

`ifdef PACKET_DECODER_TIMEOUT_EN
  localparam int TimeoutClocks = ClockFrequency / BaudRate * TimeoutBits;
  localparam int GapWidth      = $clog2(TimeoutClocks);

  logic [GapWidth-1:0] gapCount;

  // Gap counter: clocks since the last byte strobe, only while a frame is being assembled.
  always_ff @(posedge iClock) begin
    if (!iResetN || !inFrame || iReceived) begin
      gapCount <= '0;
    end else begin
      gapCount <= gapCount + 1'b1;
    end
  end

  assign timeoutHit = inFrame && !iReceived && (gapCount == GapWidth'(TimeoutClocks - 1));
`else
  localparam int unusedTimeoutClocks = ClockFrequency / BaudRate * TimeoutBits;

  assign timeoutHit = 1'b0;
`endif

  // State, frame bookkeeping and registered status pulses.
  always_ff @(posedge iClock) begin
    if (!iResetN) begin
      state       <= sHunt;
      frameLength <= 8'd0;
      byteCount   <= 8'd0;
      sum         <= 8'd0;
      frameOk     <= 1'b0;
      frameError  <= 1'b0;
      errorCode   <= 2'd0;
      overrun     <= 1'b0;
    end else begin
      state       <= stateNext;
      frameLength <= frameLengthNext;
      byteCount   <= byteCountNext;
      sum         <= sumNext;
      frameOk     <= frameOkNext;
      frameError  <= frameErrorNext;
      errorCode   <= errorCodeNext;
      overrun     <= overrunNext;
    end
  end

  // Payload buffer write; contents need no reset since only validated frames are read.
  always_ff @(posedge iClock) begin
    if (iResetN && bufferWrite) begin
      buffer[byteCount[IndexWidth-1:0]] <= iData;
    end
  end

  // Next-state logic: frame parsing, checksum validation and drain sequencing.
  always_comb begin
    stateNext       = state;
    frameLengthNext = frameLength;
    byteCountNext   = byteCount;
    sumNext         = sum;
    frameOkNext     = 1'b0;
    frameErrorNext  = 1'b0;
    errorCodeNext   = errorCode;
    overrunNext     = 1'b0;
    bufferWrite     = 1'b0;

    case (state)
      sHunt: begin
        if (iReceived && (iData == SyncByte)) begin
          stateNext = sLength;
        end
      end

      sLength: begin
        if (iReceived) begin
          if ((iData == 8'd0) || (iData > MaxLength)) begin
            frameErrorNext = 1'b1;
            errorCodeNext  = 2'd1;
            stateNext      = sHunt;
          end else begin
            frameLengthNext = iData;
            sumNext         = iData;
            byteCountNext   = 8'd0;
            stateNext       = sPayload;
          end
        end
      end

      sPayload: begin
        if (iReceived) begin
          bufferWrite   = 1'b1;
          sumNext       = sum + iData;
          byteCountNext = byteCount + 8'd1;
          if (byteCount == lastIndex) begin
            stateNext = sChecksum;
          end
        end
      end

      sChecksum: begin
        if (iReceived) begin
          if (iData == sum) begin
            frameOkNext   = 1'b1;
            byteCountNext = 8'd0;
            stateNext     = sDrain;
          end else begin
            frameErrorNext = 1'b1;
            errorCodeNext  = 2'd2;
            stateNext      = sHunt;
          end
        end
      end

      sDrain: begin
        overrunNext = iReceived;
        if (iReady) begin
          if (byteCount == lastIndex) begin
            stateNext = sHunt;
          end else begin
            byteCountNext = byteCount + 8'd1;
          end
        end
      end

      default: begin
        stateNext = sHunt;
      end
    endcase

    // Line errors and gaps abort any frame under assembly and win over a same-cycle byte.
    if (inFrame && (iError || timeoutHit)) begin
      stateNext      = sHunt;
      bufferWrite    = 1'b0;
      frameOkNext    = 1'b0;
      frameErrorNext = 1'b1;
      errorCodeNext  = 2'd3;
    end
  end

  // Output stream is a direct view of the buffer at the drain index, zero when idle.
  always_comb begin
    oValid      = (state == sDrain);
    oData       = oValid ? buffer[byteCount[IndexWidth-1:0]] : 8'd0;
    oFirst      = oValid && (byteCount == 8'd0);
    oLast       = oValid && (byteCount == lastIndex);
    oFrameOk    = frameOk;
    oFrameError = frameError;
    oErrorCode  = errorCode;
    oOverrun    = overrun;
  end

endmodule

// File: tb/tb_serial_packet_decoder.sv
// tb/tb_serial_packet_decoder.sv - directed checks for serial_packet_decoder
module tb_serial_packet_decoder;

  logic       iClock = 1'b0;
  logic       iResetN;
  logic [7:0] iData;
  logic       iReceived;
  logic       iError;
  logic [7:0] oData;
  logic       oValid;
  logic       iReady;
  logic       oFirst;
  logic       oLast;
  logic       oFrameOk;
  logic       oFrameError;
  logic [1:0] oErrorCode;
  logic       oOverrun;

  int checkCount = 0;
  int passCount  = 0;

  int          cycle = 0;
  logic [9:0]  outQ[$];
  int          outCycle[$];
  int          okCount = 0;
  int          errCount = 0;
  int          overrunCount = 0;
  logic        holdPending = 1'b0;
  logic [10:0] heldWord = '0;

  logic [7:0] seq[$];
  logic [7:0] expect_q[$];

  always #5 iClock = ~iClock;

  serial_packet_decoder dut (
    .iClock     (iClock),
    .iResetN    (iResetN),
    .iData      (iData),
    .iReceived  (iReceived),
    .iError     (iError),
    .oData      (oData),
    .oValid     (oValid),
    .iReady     (iReady),
    .oFirst     (oFirst),
    .oLast      (oLast),
    .oFrameOk   (oFrameOk),
    .oFrameError(oFrameError),
    .oErrorCode (oErrorCode),
    .oOverrun   (oOverrun)
  );

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Output monitor at the falling edge: logs transfers, pulses and stall stability.
  always @(negedge iClock) begin
    cycle++;
    if (iResetN) begin
      if (holdPending) checkValue("stall_hold", {21'd0, oValid, oFirst, oLast, oData}, {21'd0, heldWord});
      if (oValid && iReady) begin
        outQ.push_back({oFirst, oLast, oData});
        outCycle.push_back(cycle);
      end
      if (oFrameOk) okCount++;
      if (oFrameError) errCount++;
      if (oOverrun) overrunCount++;
      holdPending = oValid && !iReady;
      heldWord    = {1'b1, oFirst, oLast, oData};
    end else begin
      holdPending = 1'b0;
    end
  end

  task automatic clearLog();
    outQ.delete();
    outCycle.delete();
    okCount      = 0;
    errCount     = 0;
    overrunCount = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge iClock);
    #2;
  endtask

  task automatic sendByte(input logic [7:0] b);
    iData     = b;
    iReceived = 1'b1;
    @(posedge iClock);
    #2;
    iReceived = 1'b0;
  endtask

  task automatic sendBytes(input logic [7:0] s[$]);
    foreach (s[i]) sendByte(s[i]);
  endtask

  task automatic sendLineError();
    iError = 1'b1;
    @(posedge iClock);
    #2;
    iError = 1'b0;
  endtask

  task automatic checkFrame(input string tag, input logic [7:0] d[$], input logic consecutive);
    checkValue({tag, "_count"}, outQ.size(), d.size());
    foreach (d[i]) begin
      if (i < outQ.size()) begin
        checkValue({tag, "_byte"}, {22'd0, outQ[i]}, {22'd0, (i == 0), (i == d.size() - 1), d[i]});
        if (consecutive && i > 0) checkValue({tag, "_gap"}, outCycle[i] - outCycle[i-1], 1);
      end
    end
  endtask

  initial begin
    iResetN   = 1'b0;
    iData     = 8'h00;
    iReceived = 1'b0;
    iError    = 1'b0;
    iReady    = 1'b1;
    idle(2);
    checkValue("reset_outputs",
               {18'd0, oData, oValid, oFirst, oLast, oFrameOk, oFrameError, oErrorCode, oOverrun}, 32'd0);
    iResetN = 1'b1;
    idle(2);

    // Good frame, iReady held high.
    clearLog();
    seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    sendBytes(seq);
    checkValue("good_frameok_n1", oFrameOk, 1);
    checkValue("good_valid_n1", oValid, 1);
    idle(6);
    expect_q = '{8'h11, 8'h22, 8'h33};
    checkFrame("good", expect_q, 1'b1);
    checkValue("good_ok_pulses", okCount, 1);
    checkValue("good_err_pulses", errCount, 0);
    checkValue("good_idle_after", oValid, 0);

    // Checksum error followed by a one-byte frame.
    clearLog();
    seq = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31};
    sendBytes(seq);
    checkValue("chk_err_pulse", oFrameError, 1);
    checkValue("chk_err_code", oErrorCode, 2);
    idle(3);
    checkValue("chk_no_output", outQ.size(), 0);
    seq = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    sendBytes(seq);
    idle(4);
    expect_q = '{8'h7E};
    checkFrame("len1", expect_q, 1'b0);
    checkValue("len1_err_count", errCount, 1);
    checkValue("len1_code_holds", oErrorCode, 2);

    // Bad lengths: above MaxPayload, then zero; trailing bytes must be ignored.
    clearLog();
    seq = '{8'hA5, 8'h11};
    sendBytes(seq);
    checkValue("len17_pulse", oFrameError, 1);
    checkValue("len17_code", oErrorCode, 1);
    seq = '{8'h01, 8'h7E, 8'h7F};
    sendBytes(seq);
    seq = '{8'hA5, 8'h00};
    sendBytes(seq);
    checkValue("len0_pulse", oFrameError, 1);
    checkValue("len0_code", oErrorCode, 1);
    seq = '{8'h01, 8'h7E, 8'h7F};
    sendBytes(seq);
    idle(4);
    checkValue("badlen_no_output", outQ.size(), 0);
    checkValue("badlen_no_ok", okCount, 0);
    checkValue("badlen_err_count", errCount, 2);

    // Maximum length frame (16 bytes 00..0F, checksum 0x10+0x78=0x88), SOF value inside payload.
    clearLog();
    seq = '{8'hA5, 8'h10};
    expect_q.delete();
    for (int i = 0; i < 16; i++) begin
      seq.push_back((i == 5) ? 8'hA5 : 8'(i));
      expect_q.push_back((i == 5) ? 8'hA5 : 8'(i));
    end
    seq.push_back(8'h88 - 8'h05 + 8'hA5);
    sendBytes(seq);
    idle(20);
    checkFrame("max", expect_q, 1'b1);
    checkValue("max_ok_pulses", okCount, 1);

    // Backpressure with iReady pattern 1,0,0,1 and one overrun byte mid-drain.
    clearLog();
    seq = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0E};
    sendBytes(seq);
    checkValue("bp_frameok", oFrameOk, 1);
    for (int k = 0; k < 16; k++) begin
      iReady    = (k % 4 == 0) || (k % 4 == 3);
      iReceived = (k == 1);
      iData     = 8'hEE;
      @(posedge iClock);
      #2;
    end
    iReceived = 1'b0;
    iReady    = 1'b1;
    idle(2);
    expect_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    checkFrame("bp", expect_q, 1'b0);
    checkValue("bp_overrun", overrunCount, 1);
    checkValue("bp_ok_pulses", okCount, 1);

    // Line error mid-payload.
    clearLog();
    seq = '{8'hA5, 8'h03, 8'h11};
    sendBytes(seq);
    sendLineError();
    checkValue("line_err_pulse", oFrameError, 1);
    checkValue("line_err_code", oErrorCode, 3);
    seq = '{8'h22, 8'h33, 8'h69};
    sendBytes(seq);
    idle(4);
    checkValue("line_no_output", outQ.size(), 0);

    // Reset mid-payload, then the remainder is ignored and a fresh frame decodes.
    clearLog();
    seq = '{8'hA5, 8'h03, 8'h11};
    sendBytes(seq);
    iResetN = 1'b0;
    idle(1);
    checkValue("midreset_outputs",
               {18'd0, oData, oValid, oFirst, oLast, oFrameOk, oFrameError, oErrorCode, oOverrun}, 32'd0);
    iResetN = 1'b1;
    seq = '{8'h22, 8'h33, 8'h69};
    sendBytes(seq);
    idle(4);
    checkValue("midreset_no_output", outQ.size(), 0);
    seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    sendBytes(seq);
    idle(6);
    expect_q = '{8'h11, 8'h22, 8'h33};
    checkFrame("after_reset", expect_q, 1'b1);

`ifdef PACKET_DECODER_TIMEOUT_EN
    // 4140-clock gap aborts; a 4000-clock gap does not.
    clearLog();
    seq = '{8'hA5, 8'h02};
    sendBytes(seq);
    idle(4145);
    checkValue("timeout_err_count", errCount, 1);
    checkValue("timeout_code", oErrorCode, 3);
    clearLog();
    seq = '{8'hA5, 8'h02, 8'h10};
    sendBytes(seq);
    idle(4000);
    seq = '{8'h20, 8'h32};
    sendBytes(seq);
    idle(4);
    expect_q = '{8'h10, 8'h20};
    checkFrame("gap4000", expect_q, 1'b1);
    checkValue("gap4000_err", errCount, 0);
`else
    // Without the timeout a long gap still completes the frame.
    clearLog();
    seq = '{8'hA5, 8'h02, 8'h10};
    sendBytes(seq);
    idle(10000);
    seq = '{8'h20, 8'h32};
    sendBytes(seq);
    idle(4);
    expect_q = '{8'h10, 8'h20};
    checkFrame("gap10000", expect_q, 1'b1);
    checkValue("gap10000_err", errCount, 0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
